vscale_alu_ovf_monitor: RTL and testbench

Synthesizable, parametrised successor to the bench-side ALU overflow checks: it sits beside the vscale pipeline ALU, watches every qualified ADD/SUB result, and classifies it into four events (signed/unsigned overflow for add and subtract). Per-event saturating counters, sticky flags, an enable mask and a threshold interrupt are exposed through a small register read/write port, so overflow statistics survive into silicon and can be read by firmware or the HTIF path.

---
 rtl/vscale_alu_ovf_monitor_pkg.sv | 23 ++
 rtl/vscale_sat_counter.sv | 35 +++
 rtl/vscale_alu_ovf_monitor.sv | 123 ++++++++++++
 tb/tb_vscale_alu_ovf_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_alu_ovf_monitor_pkg.sv
// Shared constants for the vscale ALU overflow monitor: opcodes, event indices,
// register addresses and reset values.
package vscale_alu_ovf_monitor_pkg;

   localparam int ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd10;

   localparam int N_EV = 4;

   typedef enum logic [1:0] {
      EV_SADD = 2'd0,
      EV_UADD = 2'd1,
      EV_SSUB = 2'd2,
      EV_USUB = 2'd3
   } ev_idx_e;

   localparam logic [2:0] REG_FLAGS = 3'd4;
   localparam logic [2:0] REG_MASK  = 3'd5;

   localparam logic [N_EV-1:0] MASK_RST = 4'hF;

endpackage

// File: rtl/vscale_sat_counter.sv
// Saturating up-counter with a load port; load takes priority over increment.
module vscale_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             load,
   input  logic [CNT_W-1:0] load_data,
   output logic [CNT_W-1:0] value
);

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_data;
      end else if (inc && (value_q != {CNT_W{1'b1}})) begin
         value_d = value_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/vscale_alu_ovf_monitor.sv
// Classifies retiring ADD/SUB results into overflow events and keeps per-event
// saturating counters, sticky flags, an enable mask and a threshold interrupt.
module vscale_alu_ovf_monitor
   import vscale_alu_ovf_monitor_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CNT_W  = 16,
   parameter int THRESH = 2**CNT_W - 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_valid,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [XLEN-1:0]     alu_in1,
   input  logic [XLEN-1:0]     alu_in2,
   input  logic [XLEN-1:0]     alu_out,
   input  logic                rd_en,
   input  logic [2:0]          rd_addr,
   output logic [CNT_W-1:0]    rd_data,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic [2:0]          wr_addr,
   input  logic [CNT_W-1:0]    wr_data,
   output logic                irq
);

   localparam int MSB = XLEN - 1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   logic [N_EV-1:0]  ev_q,    ev_d;
   logic [N_EV-1:0]  flags_q, flags_d;
   logic [N_EV-1:0]  mask_q,  mask_d;
   logic             irq_q,   irq_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] cnt [N_EV];

   logic is_add, is_sub;

   always_comb begin
      is_add = alu_valid && (alu_op == ALU_OP_ADD);
      is_sub = alu_valid && (alu_op == ALU_OP_SUB);
      ev_d = '0;
      ev_d[EV_SADD] = is_add && (alu_in1[MSB] == alu_in2[MSB]) && (alu_out[MSB] != alu_in1[MSB]);
      ev_d[EV_UADD] = is_add && (alu_out < alu_in1);
      ev_d[EV_SSUB] = is_sub && (alu_in1[MSB] != alu_in2[MSB]) && (alu_out[MSB] != alu_in1[MSB]);
      ev_d[EV_USUB] = is_sub && (alu_in1 < alu_in2);
   end

   // Counters only see events whose mask bit is set; a register write to the
   // same counter overrides the increment inside the counter.
   for (genvar i = 0; i < N_EV; i++) begin : g_cnt
      vscale_sat_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc       (ev_q[i] & mask_q[i]),
         .load      (wr_en && (wr_addr == 3'(i))),
         .load_data (wr_data),
         .value     (cnt[i])
      );
   end

   always_comb begin
      flags_d = flags_q;
      mask_d  = mask_q;
      if (wr_en && (wr_addr == REG_FLAGS)) begin
         flags_d = flags_q & ~wr_data[N_EV-1:0];
      end
      if (wr_en && (wr_addr == REG_MASK)) begin
         mask_d = wr_data[N_EV-1:0];
      end
      // New events are OR'd in after the clear so a colliding W1C cannot drop them.
      flags_d = flags_d | ev_q;
   end

   always_comb begin
      irq_d = 1'b0;
      for (int i = 0; i < N_EV; i++) begin
         if (mask_q[i] && (cnt[i] >= THRESH_C)) begin
            irq_d = 1'b1;
         end
      end
   end

   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = '0;
      if (rd_en) begin
         if (!rd_addr[2]) begin
            rd_data_d = cnt[rd_addr[1:0]];
         end else if (rd_addr == REG_FLAGS) begin
            rd_data_d = CNT_W'(flags_q);
         end else if (rd_addr == REG_MASK) begin
            rd_data_d = CNT_W'(mask_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_q       <= '0;
         flags_q    <= '0;
         mask_q     <= MASK_RST;
         irq_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         ev_q       <= ev_d;
         flags_q    <= flags_d;
         mask_q     <= mask_d;
         irq_q      <= irq_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_vscale_alu_ovf_monitor.sv
// Directed bench for vscale_alu_ovf_monitor: classification vectors plus
// saturation/irq, mask, collision and mid-stream reset sequences.
module tb_vscale_alu_ovf_monitor;
   import vscale_alu_ovf_monitor_pkg::*;

   localparam int XLEN   = 32;
   localparam int CNT_W  = 4;
   localparam int THRESH = 10;
   localparam logic [3:0] OP_XOR = 4'd4;

   logic             clk = 1'b0;
   logic             reset;
   logic             alu_valid;
   logic [3:0]       alu_op;
   logic [XLEN-1:0]  alu_in1, alu_in2, alu_out;
   logic             rd_en;
   logic [2:0]       rd_addr;
   logic [CNT_W-1:0] rd_data;
   logic             rd_valid;
   logic             wr_en;
   logic [2:0]       wr_addr;
   logic [CNT_W-1:0] wr_data;
   logic             irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vscale_alu_ovf_monitor #(
      .XLEN   (XLEN),
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_op    (alu_op),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_out   (alu_out),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .irq       (irq)
   );

   typedef struct {
      logic [3:0]  op;
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic [3:0]  ev;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [3:0] d);
      rd_en   = 1'b1;
      rd_addr = a;
      step();
      rd_en = 1'b0;
      d = rd_data;
      check($sformatf("rd_valid@%0d", a), {31'd0, rd_valid}, 32'd1);
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic clear_all();
      for (int j = 0; j < 4; j++) wr(3'(j), 4'd0);
      wr(3'd4, 4'hF);
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] y);
      alu_op  = op;
      alu_in1 = a;
      alu_in2 = b;
      alu_out = y;
   endtask

   logic [3:0] d;

   initial begin
      vecs[0] = '{ALU_OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0001};
      vecs[1] = '{ALU_OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0010};
      vecs[2] = '{ALU_OP_SUB, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      vecs[3] = '{ALU_OP_SUB, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100};
      vecs[4] = '{ALU_OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0000};
      vecs[5] = '{ALU_OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0011};
      vecs[6] = '{ALU_OP_SUB, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1100};
      vecs[7] = '{OP_XOR,     1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0000};
      vecs[8] = '{ALU_OP_ADD, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000};

      reset = 1'b1; alu_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      set_op(ALU_OP_ADD, '0, '0, '0);
      step(); step();
      reset = 1'b0;

      check("rst irq", {31'd0, irq}, 32'd0);
      check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst rd_data", {28'd0, rd_data}, 32'd0);
      rd(3'd5, d); check("rst mask", {28'd0, d}, 32'hF);
      rd(3'd4, d); check("rst flags", {28'd0, d}, 32'h0);
      rd(3'd0, d); check("rst cnt0", {28'd0, d}, 32'h0);

      // classification table
      for (int i = 0; i < 9; i++) begin
         clear_all();
         set_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y);
         alu_valid = vecs[i].valid;
         step();
         alu_valid = 1'b0;
         step();
         for (int j = 0; j < 4; j++) begin
            rd(3'(j), d);
            check($sformatf("v%0d cnt%0d", i, j), {28'd0, d}, {31'd0, vecs[i].ev[j]});
         end
         rd(3'd4, d);
         check($sformatf("v%0d flags", i), {28'd0, d}, {28'd0, vecs[i].ev});
      end

      // saturation and threshold irq
      clear_all();
      set_op(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
      alu_valid = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         if (k == 20) alu_valid = 1'b0;
         check($sformatf("sat irq k%0d", k), {31'd0, irq}, {31'd0, (k >= 12)});
      end
      rd(3'd0, d); check("sat cnt0", {28'd0, d}, 32'd15);
      rd(3'd4, d); check("sat flags", {28'd0, d}, 32'd1);
      wr(3'd0, 4'd0);
      check("irq after cnt write", {31'd0, irq}, 32'd1);
      step();
      check("irq falls", {31'd0, irq}, 32'd0);

      // masked event
      clear_all();
      wr(3'd5, 4'hE);
      alu_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 3) alu_valid = 1'b0;
         check($sformatf("mask irq k%0d", k), {31'd0, irq}, 32'd0);
      end
      rd(3'd0, d); check("mask cnt0", {28'd0, d}, 32'd0);
      rd(3'd4, d); check("mask flags", {28'd0, d}, 32'd1);
      rd(3'd5, d); check("mask rd", {28'd0, d}, 32'hE);
      wr(3'd0, 4'd12);
      step();
      check("masked high cnt irq", {31'd0, irq}, 32'd0);
      wr(3'd5, 4'hF);
      step();
      check("unmask irq", {31'd0, irq}, 32'd1);
      wr(3'd0, 4'd0);
      step();
      check("unmask irq off", {31'd0, irq}, 32'd0);

      // W1C colliding with an event landing
      clear_all();
      alu_valid = 1'b1;
      step();
      alu_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h1;
      step();
      wr_en = 1'b0;
      rd(3'd4, d); check("w1c collide flags", {28'd0, d}, 32'd1);
      rd(3'd0, d); check("w1c collide cnt0", {28'd0, d}, 32'd1);

      // counter write colliding with an increment
      alu_valid = 1'b1;
      step();
      alu_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd7;
      step();
      wr_en = 1'b0;
      rd(3'd0, d); check("cnt write wins", {28'd0, d}, 32'd7);
      wr(3'd4, 4'hF);
      rd(3'd4, d); check("w1c clears", {28'd0, d}, 32'd0);

      // read in the same cycle as a write sees the old value
      rd_en = 1'b1; rd_addr = 3'd0;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd3;
      step();
      rd_en = 1'b0; wr_en = 1'b0;
      check("rd during wr", {28'd0, rd_data}, 32'd7);
      rd(3'd0, d); check("rd after wr", {28'd0, d}, 32'd3);

      wr(3'd6, 4'hF);
      rd(3'd6, d); check("reg6 zero", {28'd0, d}, 32'd0);
      rd(3'd5, d); check("reg6 no alias", {28'd0, d}, 32'hF);

      // reset with an event in flight
      wr(3'd5, 4'h5);
      alu_valid = 1'b1;
      step();
      alu_valid = 1'b0;
      step();
      wr(3'd2, 4'd12);
      step();
      check("pre-reset irq", {31'd0, irq}, 32'd1);
      rd(3'd4, d); check("pre-reset flags", {28'd0, d}, 32'd1);
      alu_valid = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      alu_valid = 1'b0;
      check("post-reset irq", {31'd0, irq}, 32'd0);
      step(); step();
      for (int j = 0; j < 4; j++) begin
         rd(3'(j), d);
         check($sformatf("post-reset cnt%0d", j), {28'd0, d}, 32'd0);
      end
      rd(3'd4, d); check("post-reset flags", {28'd0, d}, 32'd0);
      rd(3'd5, d); check("post-reset mask", {28'd0, d}, 32'hF);
      check("post-reset irq late", {31'd0, irq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
